// File: rtl/freq_pkg.sv
// Shared digit type and 7-segment codes for the frequency-meter display path.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package freq_pkg;

   localparam int N_DIGITS = 5;

   typedef logic [4:0] digit_t;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;

   // Anything outside 0..9 renders as a centre dash so bad data is visible.
   function automatic logic [6:0] bcd_to_seg(input digit_t d);
      logic [6:0] s;
      case (d)
         5'd0:    s = SEG_0;
         5'd1:    s = SEG_1;
         5'd2:    s = SEG_2;
         5'd3:    s = SEG_3;
         5'd4:    s = SEG_4;
         5'd5:    s = SEG_5;
         5'd6:    s = SEG_6;
         5'd7:    s = SEG_7;
         5'd8:    s = SEG_8;
         5'd9:    s = SEG_9;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD to 7-segment decoder for the currently scanned digit.
module seg_decoder
   import freq_pkg::*;
(
   input  digit_t     i_digit,
   output logic [6:0] o_seg
);

   assign o_seg = bcd_to_seg(i_digit);

endmodule

// File: rtl/display_varredura.sv
// Multiplexed 5-digit 7-segment scanner; new values are swapped in only at a
// frame boundary so a frame never mixes old and new digits.
module display_varredura
   import freq_pkg::*;
#(
   parameter int SCAN_DIV = 1000
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  digit_t              digit0,
   input  digit_t              digit1,
   input  digit_t              digit2,
   input  digit_t              digit3,
   input  digit_t              digit4,
   input  logic                blank_en,
   output logic [6:0]          seg,
   output logic [N_DIGITS-1:0] an,
   output logic                frame_done
);

   localparam int              PC_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PC_W-1:0] PC_LAST  = PC_W'(SCAN_DIV - 1);
   localparam logic [2:0]      IDX_LAST = 3'(N_DIGITS - 1);

   logic [PC_W-1:0]            r_pc;
   logic [2:0]                 r_idx;
   digit_t [N_DIGITS-1:0]      r_active;
   digit_t [N_DIGITS-1:0]      r_pending;
   logic                       r_pend;
   logic                       r_blank_en;

   digit_t [N_DIGITS-1:0]      w_load_digits;
   logic                       w_slot_end;
   logic                       w_boundary;
   logic [N_DIGITS-1:0]        w_lz;
   digit_t                     w_sel;
   logic [6:0]                 w_seg;
   logic                       w_blank;
   logic [N_DIGITS-1:0]        w_an_onehot;

   assign w_load_digits = {digit4, digit3, digit2, digit1, digit0};
   assign w_slot_end    = (r_pc == PC_LAST);
   assign w_boundary    = w_slot_end && (r_idx == IDX_LAST);
   assign frame_done    = w_boundary;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc  <= '0;
         r_idx <= '0;
      end else if (w_slot_end) begin
         r_pc  <= '0;
         r_idx <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
      end else begin
         r_pc  <= r_pc + 1'b1;
      end
   end

   // A load landing on the boundary itself bypasses pending so it is not
   // held back a whole frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active  <= '0;
         r_pending <= '0;
         r_pend    <= 1'b0;
      end else if (w_boundary) begin
         if (load) begin
            r_active <= w_load_digits;
         end else if (r_pend) begin
            r_active <= r_pending;
         end
         r_pend <= 1'b0;
      end else if (load) begin
         r_pending <= w_load_digits;
         r_pend    <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blank_en <= 1'b0;
      end else if (w_slot_end) begin
         r_blank_en <= blank_en;
      end
   end

   // w_lz[i] is set when digit i and every digit above it are zero.
   always_comb begin
      logic zero_above;
      zero_above = 1'b1;
      w_lz       = '0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above && (r_active[i] == '0);
         w_lz[i]    = zero_above;
      end
   end

   assign w_sel       = r_active[r_idx];
   assign w_blank     = r_blank_en && (r_idx != 3'd0) && w_lz[r_idx];
   assign w_an_onehot = {{(N_DIGITS-1){1'b0}}, 1'b1} << r_idx;

   seg_decoder u_seg_decoder (
      .i_digit (w_sel),
      .o_seg   (w_seg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= '0;
         an  <= '0;
      end else if (w_blank) begin
         seg <= '0;
         an  <= '0;
      end else begin
         seg <= w_seg;
         an  <= w_an_onehot;
      end
   end

endmodule

// File: tb/tb_display_varredura.sv
// Bench for display_varredura: scenario tasks against a cycle-count based
// model of the scanner (slot = time / SCAN_DIV, swap at frame ends).
module tb_display_varredura;

   localparam int SD = 4;
   localparam int FR = 5 * SD;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load = 1'b0;
   logic       blank_en = 1'b0;
   logic [4:0] d0, d1, d2, d3, d4;
   logic [6:0] seg;
   logic [4:0] an;
   logic       frame_done;

   display_varredura #(.SCAN_DIV(SD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .digit0     (d0),
      .digit1     (d1),
      .digit2     (d2),
      .digit3     (d3),
      .digit4     (d4),
      .blank_en   (blank_en),
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // model state: m_t counts clock edges since reset release
   int         m_t;
   logic [4:0] m_act [5];
   logic [4:0] m_pnd [5];
   logic       m_pend;
   logic       m_blank;
   logic [6:0] e_seg;
   logic [4:0] e_an;
   logic       e_fd;

   function automatic logic [6:0] seg_of(input logic [4:0] d);
      case (d)
         5'd0: return 7'h3F;
         5'd1: return 7'h06;
         5'd2: return 7'h5B;
         5'd3: return 7'h4F;
         5'd4: return 7'h66;
         5'd5: return 7'h6D;
         5'd6: return 7'h7D;
         5'd7: return 7'h07;
         5'd8: return 7'h7F;
         5'd9: return 7'h6F;
         default: return 7'h40;
      endcase
   endfunction

   task automatic set_digits(input int v4, input int v3, input int v2, input int v1, input int v0);
      d4 = 5'(v4); d3 = 5'(v3); d2 = 5'(v2); d1 = 5'(v1); d0 = 5'(v0);
   endtask

   task automatic model_reset();
      m_t = 0;
      m_pend = 1'b0;
      m_blank = 1'b0;
      for (int j = 0; j < 5; j++) begin
         m_act[j] = '0;
         m_pnd[j] = '0;
      end
      e_seg = '0; e_an = '0; e_fd = 1'b0;
   endtask

   // One clock: predict outputs from pre-edge model state, advance model,
   // clock the DUT, return at the following negedge.
   task automatic cyc();
      int         slot;
      bit         blank;
      logic [6:0] ns;
      logic [4:0] na;
      logic [4:0] din [5];
      slot  = (m_t / SD) % 5;
      blank = m_blank && (slot != 0);
      for (int j = slot; j < 5; j++) if (m_act[j] != 0) blank = 0;
      ns = blank ? 7'h00 : seg_of(m_act[slot]);
      na = blank ? 5'b0 : 5'(1 << slot);
      din = '{d0, d1, d2, d3, d4};
      if (m_t % FR == FR - 1) begin
         if (load) m_act = din;
         else if (m_pend) m_act = m_pnd;
         m_pend = 1'b0;
      end else if (load) begin
         m_pnd  = din;
         m_pend = 1'b1;
      end
      if (m_t % SD == SD - 1) m_blank = blank_en;
      m_t++;
      @(posedge clk);
      #1 load = 1'b0;
      e_seg = ns;
      e_an  = na;
      e_fd  = (m_t % FR == FR - 1);
      @(negedge clk);
   endtask

   task automatic align();
      while (m_t % FR != 0) cyc();
   endtask

   task automatic test_reset();
      checks++;
      if ({seg, an, frame_done} !== 13'b0) begin
         failures++;
         $display("FAIL reset_idle got seg=%h an=%b fd=%b want 0", seg, an, frame_done);
      end
      while ((m_t / SD) % 5 != 2) begin
         cyc();
         checks++;
         if ({seg, an, frame_done} !== {e_seg, e_an, e_fd}) begin
            failures++;
            $display("FAIL reset_run t=%0d got seg=%h an=%b fd=%b want seg=%h an=%b fd=%b", m_t, seg, an, frame_done, e_seg, e_an, e_fd);
         end
      end
      cyc();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({seg, an, frame_done} !== 13'b0) begin
         failures++;
         $display("FAIL reset_async got seg=%h an=%b fd=%b want 0", seg, an, frame_done);
      end
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if ({seg, an} !== 12'b0) begin
         failures++;
         $display("FAIL reset_release got seg=%h an=%b want 0", seg, an);
      end
      cyc();
      checks++;
      if (seg !== 7'h3F || an !== 5'b00001) begin
         failures++;
         $display("FAIL reset_first_digit got seg=%h an=%b want seg=3f an=00001", seg, an);
      end
   endtask

   task automatic test_load_12345();
      logic [6:0] xs [5];
      int         fd_at [$];
      xs = '{7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
      set_digits(1, 2, 3, 4, 5);
      load = 1'b1;
      cyc();
      align();
      for (int i = 0; i < 2 * FR; i++) begin
         cyc();
         checks++;
         if ({seg, an, frame_done} !== {e_seg, e_an, e_fd}) begin
            failures++;
            $display("FAIL l12345_model t=%0d got seg=%h an=%b fd=%b want seg=%h an=%b fd=%b", m_t, seg, an, frame_done, e_seg, e_an, e_fd);
         end
         checks++;
         if (seg !== xs[(i / SD) % 5] || an !== 5'(1 << ((i / SD) % 5))) begin
            failures++;
            $display("FAIL l12345_slot i=%0d got seg=%h an=%b want seg=%h an=%b", i, seg, an, xs[(i / SD) % 5], 5'(1 << ((i / SD) % 5)));
         end
         if (frame_done === 1'b1) fd_at.push_back(i);
      end
      checks++;
      if (fd_at.size() != 2 || fd_at[1] - fd_at[0] != FR) begin
         failures++;
         $display("FAIL l12345_frame_done got pulses=%0d want 2 spaced %0d", fd_at.size(), FR);
      end
   endtask

   task automatic test_blanking();
      logic [6:0] xs_on [5];
      logic [4:0] xa_on [5];
      xs_on = '{7'h5B, 7'h66, 7'h00, 7'h00, 7'h00};
      xa_on = '{5'b00001, 5'b00010, 5'b00000, 5'b00000, 5'b00000};
      set_digits(0, 0, 0, 4, 2);
      load = 1'b1;
      blank_en = 1'b1;
      cyc();
      align();
      for (int i = 0; i < FR; i++) begin
         cyc();
         checks++;
         if ({seg, an, frame_done} !== {e_seg, e_an, e_fd}) begin
            failures++;
            $display("FAIL blank_on_model t=%0d got seg=%h an=%b want seg=%h an=%b", m_t, seg, an, e_seg, e_an);
         end
         checks++;
         if (seg !== xs_on[i / SD] || an !== xa_on[i / SD]) begin
            failures++;
            $display("FAIL blank_on slot=%0d got seg=%h an=%b want seg=%h an=%b", i / SD, seg, an, xs_on[i / SD], xa_on[i / SD]);
         end
      end
      blank_en = 1'b0;
      align();
      for (int i = 0; i < FR; i++) begin
         cyc();
         checks++;
         if ({seg, an, frame_done} !== {e_seg, e_an, e_fd}) begin
            failures++;
            $display("FAIL blank_off_model t=%0d got seg=%h an=%b want seg=%h an=%b", m_t, seg, an, e_seg, e_an);
         end
         checks++;
         if (i / SD >= 2 && (seg !== 7'h3F || an !== 5'(1 << (i / SD)))) begin
            failures++;
            $display("FAIL blank_off slot=%0d got seg=%h an=%b want seg=3f", i / SD, seg, an);
         end
      end
   endtask

   task automatic test_load_midframe();
      logic [6:0] xs [5];
      xs = '{7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
      set_digits(1, 2, 3, 4, 5);
      load = 1'b1;
      cyc();
      align();
      for (int i = 0; i < FR; i++) begin
         if (i == SD + 1) begin
            set_digits(9, 9, 9, 9, 9);
            load = 1'b1;
         end
         cyc();
         checks++;
         if ({seg, an, frame_done} !== {e_seg, e_an, e_fd}) begin
            failures++;
            $display("FAIL midframe_model t=%0d got seg=%h an=%b want seg=%h an=%b", m_t, seg, an, e_seg, e_an);
         end
         checks++;
         if (seg !== xs[i / SD]) begin
            failures++;
            $display("FAIL midframe_old i=%0d got seg=%h want %h", i, seg, xs[i / SD]);
         end
      end
      cyc();
      checks++;
      if (seg !== 7'h6F || an !== 5'b00001) begin
         failures++;
         $display("FAIL midframe_new got seg=%h an=%b want seg=6f an=00001", seg, an);
      end
   endtask

   task automatic test_load_boundary();
      while (m_t % FR != FR - 1) cyc();
      set_digits(5, 4, 3, 2, 1);
      load = 1'b1;
      cyc();
      cyc();
      checks++;
      if (seg !== 7'h06 || an !== 5'b00001) begin
         failures++;
         $display("FAIL boundary_load got seg=%h an=%b want seg=06 an=00001", seg, an);
      end
      cyc();
      set_digits(1, 1, 1, 1, 1);
      load = 1'b1;
      cyc();
      repeat (5) cyc();
      set_digits(2, 2, 2, 2, 2);
      load = 1'b1;
      cyc();
      align();
      for (int i = 0; i < FR; i++) begin
         cyc();
         checks++;
         if ({seg, an, frame_done} !== {e_seg, e_an, e_fd}) begin
            failures++;
            $display("FAIL two_loads_model t=%0d got seg=%h an=%b want seg=%h an=%b", m_t, seg, an, e_seg, e_an);
         end
         checks++;
         if (seg !== 7'h5B) begin
            failures++;
            $display("FAIL two_loads i=%0d got seg=%h want 5b", i, seg);
         end
      end
   endtask

   task automatic test_invalid();
      logic [6:0] xs [5];
      logic [4:0] xa [5];
      xs = '{7'h3F, 7'h3F, 7'h40, 7'h00, 7'h00};
      xa = '{5'b00001, 5'b00010, 5'b00100, 5'b00000, 5'b00000};
      set_digits(0, 0, 12, 0, 0);
      load = 1'b1;
      blank_en = 1'b1;
      cyc();
      align();
      for (int i = 0; i < FR; i++) begin
         cyc();
         checks++;
         if ({seg, an, frame_done} !== {e_seg, e_an, e_fd}) begin
            failures++;
            $display("FAIL invalid_model t=%0d got seg=%h an=%b want seg=%h an=%b", m_t, seg, an, e_seg, e_an);
         end
         checks++;
         if (seg !== xs[i / SD] || an !== xa[i / SD]) begin
            failures++;
            $display("FAIL invalid slot=%0d got seg=%h an=%b want seg=%h an=%b", i / SD, seg, an, xs[i / SD], xa[i / SD]);
         end
      end
      blank_en = 1'b0;
   endtask

   task automatic test_random();
      int v [5];
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            for (int j = 0; j < 5; j++) begin
               int r;
               r = $urandom_range(0, 9);
               v[j] = (r < 5) ? 0 : (r < 8) ? $urandom_range(1, 9) : $urandom_range(10, 31);
            end
            set_digits(v[4], v[3], v[2], v[1], v[0]);
            load = 1'b1;
         end
         if ($urandom_range(0, 29) == 0) blank_en = ~blank_en;
         cyc();
         checks++;
         if ({seg, an, frame_done} !== {e_seg, e_an, e_fd}) begin
            failures++;
            $display("FAIL random t=%0d got seg=%h an=%b fd=%b want seg=%h an=%b fd=%b", m_t, seg, an, frame_done, e_seg, e_an, e_fd);
         end
      end
   endtask

   initial begin
      set_digits(0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_load_12345();
      test_blanking();
      test_load_midframe();
      test_load_boundary();
      test_invalid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/display_varredura.md
# display_varredura

Multiplexed 7-segment display scanner for the frequency meter. Takes the five stored count digits produced by the measurement controller and drives a shared 5-digit common-segment display, one digit at a time. A new value is captured on a one-cycle load strobe and shown only from a frame boundary, so the display never tears. Optional leading-zero blanking is supported.

## Interface
- SCAN_DIV, 1000: clock cycles each digit stays lit (≥2).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle strobe; capture digit0..digit4.
- digit0..digit4  in  5 each  BCD digit, digit0 = least significant; values 10–31 are invalid.
- blank_en  in  1  enable leading-zero blanking (level, sampled per slot).
- seg  out  7  {g,f,e,d,c,b,a}, active-high, registered.
- an  out  5  one-hot digit enable, an[i] lights digit i, active-high, registered.
- frame_done  out  1  one-cycle pulse at the end of each 5-digit frame.

## Operation
- Registers: prescaler pc (0..SCAN_DIV-1), slot index idx (0..4), active[5], pending[5], pend flag.
- pc increments each cycle; at pc = SCAN_DIV-1 it wraps to 0 and idx advances (4 wraps to 0).
- Frame boundary: pc = SCAN_DIV-1 and idx = 4. frame_done pulses on that cycle.
- load: digits go to pending, pend set. Multiple loads before a boundary: last wins.
- At a boundary with pend = 1: pending copies to active, pend clears.
- load on the boundary cycle: the incoming digits go straight to active, pend clears. The load is not deferred one frame.
- Decode uses fixed values:
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F.
  - Invalid (>9)→40, a dash.
- Blanking applies when blank_en = 1. Slot i > 0 is blank if active[i] and all higher digits are 0. A blank slot drives an = 0 and seg = 0. Slot 0 is never blanked.
- An invalid digit counts as nonzero for blanking.

## Timing
- Reset values: seg = 0, an = 0, frame_done = 0, pc = 0, idx = 0, active = 0, pending = 0, pend = 0.
- Reset is asynchronous. Assertion mid-scan forces all outputs to 0 immediately.
- seg/an are registered and reflect idx and active one cycle late.
  - The first cycle after reset release: seg = 0, an = 0.
  - Second cycle: an = 00001, seg = 3F.
- Each slot is driven for exactly SCAN_DIV cycles. A frame is 5·SCAN_DIV cycles.
- Load-to-display latency is at most 5·SCAN_DIV + 1 cycles.
  - The new value first appears on slot 0, one cycle after the boundary.
- blank_en change takes effect at the next slot change.

## Structure
- Package freq_pkg:
  - N_DIGITS = 5.
  - typedef digit_t = logic [4:0].
  - SEG_0..SEG_9 and SEG_DASH constants.
  - function bcd_to_seg.
- One combinational sub-module seg_decoder (digit_t in, 7-bit seg out), instantiated once on the selected digit.
- The scanner FSM is just idx, implicit in the counters. No separate state enum.

## Test plan
All scenarios use SCAN_DIV = 4.
- Reset mid-scan: rst_n low at idx = 2 → seg = 0 and an = 0 that instant. After release, the second cycle shows an = 00001, seg = 3F.
- Load "12345" at idle (digit4..0 = 1,2,3,4,5) → after the boundary:
  - an = 00001, 00010, 00100, 01000, 10000, each for 4 cycles.
  - seg = 6D, 66, 4F, 5B, 06 respectively.
  - frame_done pulses every 20 cycles.
- blank_en = 1 with value 00042 → slots 2–4 give an = 0, seg = 0; slot 0 gives seg = 5B; slot 1 gives seg = 66. With blank_en = 0, slots 2–4 show 3F.
- Load "99999" at idx = 1 over an active "12345" → the current frame finishes showing 12345, and slot 0 of the next frame shows 6F.
- Load coinciding with the boundary cycle → the new value appears in the immediately following frame. Two loads within one frame (11111, then 22222) → only 22222 is displayed.
- digit2 = 12 → slot 2 shows seg = 40. With blank_en = 1 and upper digits 0, slots 0–2 are lit and slots 3–4 are blank.
